encoder_4_to_2_seq: RTL and testbench
=====================================

Name: encoder_4_to_2_seq

Overview:
- Registered 4-to-2 priority encoder with request capture and a valid/ready output handshake; inverse of the team's 2-to-4 select decoder.
- Collects one-hot/pulse request lines into a pending register and emits each pending request as a 2-bit select code, highest index first.
- The code is held until the downstream consumer accepts it.
- Sits between event/request sources and decoder-driven select logic.

Parameters:
- N_IN, 4, number of request lines; fixed at 4 for this block.
- CODE_W, 2, code width; equals log2(N_IN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- d_in  input  4  request lines, sampled every rising edge; bit i means "request code i".
- code_out  output  2  encoded index of the presented request.
- valid_out  output  1  code_out is valid.
- ready_in  input  1  consumer accepts code_out when valid_out && ready_in at a rising edge.
- pending_out  output  4  current pending register, for status.
- drop_out  output  1  one-cycle pulse: a request hit an already-pending bit and was merged (lost).
- err_out  output  1  sticky multi-hot error flag; see Optional Feature.

Behaviour:
- Reset (rst_n low, async): pend=0, code_out=0, valid_out=0, drop_out=0, err_out=0, FSM=IDLE. Takes effect immediately regardless of clk. Any pending or held code is discarded; no partial handshake survives.
- Capture, every edge: pend_next = (pend & ~clr) | d_in.
  - clr is the one-hot of the index loaded this edge (0 if no load).
  - If d_in sets the same bit that is being cleared, the bit stays set: a new request wins over clear.
- drop_out, registered: asserted the edge after any cycle where d_in[i] && pend[i] && !clr[i] for some i; otherwise 0.
- Priority select: sel = highest set index of pend (3 > 2 > 1 > 0). The encode uses the registered pend only; d_in of the current cycle is not bypassed.
- FSM states:
  - IDLE (valid_out=0):
    - If pend != 0: load code_out=sel, clr=onehot(sel), go HOLD.
    - Else stay IDLE.
  - HOLD (valid_out=1; code_out stable, must not change while valid_out=1):
    - If ready_in and pend (after clr of prior load) != 0: reload code_out=sel, clr=onehot(sel), stay HOLD. This gives back-to-back throughput of one code per cycle.
    - If ready_in and pend == 0: valid_out=0, go IDLE.
    - If !ready_in: hold.
- Latency: d_in pulse at edge t sets pend at t; code_out/valid_out appear at edge t+1 (2 edges from the request, when idle).
- Lower-index requests can starve under continuous higher-index traffic; this is accepted behaviour (strict priority).
- ready_in while valid_out=0 is ignored.
- Simultaneous multiple requests in one cycle are all captured; they are served over successive handshakes in priority order.

Optional Feature:
- Macro: ENCODER_ONEHOT_CHECK_EN.
- Defined:
  - err_out sets (registered, next edge) when d_in has more than one bit set in a cycle.
  - err_out stays set until rst_n is asserted.
  - Capture behaviour is unchanged.
- Undefined: err_out is tied to 0 and the check logic is not compiled.

Test Plan:
- Reset: hold rst_n=0 mid-HOLD with code_out=3 -> valid_out, pend, code_out, err_out go to 0 immediately without a clk edge; after release, IDLE with no output.
- Single request: d_in=4'b0100 for one cycle, ready_in=1 -> valid_out=1, code_out=2 exactly 2 edges after the request, for one cycle; pending_out returns to 0.
- Multi-request priority: d_in=4'b1011 in one cycle, ready_in=1 -> codes 3, 1, 0 on consecutive cycles, then valid_out=0; err_out=1 only if ENCODER_ONEHOT_CHECK_EN is defined, else err_out stays 0.
- Backpressure: d_in=4'b0001, ready_in=0 for 5 cycles -> code_out=0, valid_out=1 held stable for all 5; accepted on the first ready_in=1 edge.
- Merge/drop: pend[2]=1 held, then d_in=4'b0100 again -> drop_out pulses one cycle; code 2 is emitted only once.
- Set-wins-over-clear: d_in=4'b1000 on the same cycle that code 3 is loaded -> pend[3] stays 1; code 3 is emitted a second time after the first is accepted.

Source files
------------

// File: rtl/encoder_4_to_2_seq.sv
// Registered 4-to-2 priority encoder: captures request pulses into a pending set and
// presents them one code at a time over a valid/ready handshake. Optional: ENCODER_ONEHOT_CHECK_EN.
module encoder_4_to_2_seq #(
  parameter int N_IN   = 4,
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   d_in,
  output logic [CODE_W-1:0] code_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [N_IN-1:0]   pending_out,
  output logic              drop_out,
  output logic              err_out
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [N_IN-1:0]     pend_reg, pend_next;
  logic [N_IN-1:0]     clr, hit;
  logic [CODE_W-1:0]   code_reg, code_next, sel;
  logic                drop_reg, drop_next;
  logic                load;

  // Ascending scan lets the highest set index overwrite lower ones.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pend_reg[i]) sel = CODE_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|pend_reg) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ready_in) begin
          if (|pend_reg) load = 1'b1;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) code_next = sel;
  end

  assign clr = load ? (N_IN'(1) << sel) : '0;

  // A fresh request on a bit being cleared this edge is not a merge; it simply re-arms the bit.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_hit
    assign hit[gi] = d_in[gi] & pend_reg[gi] & ~clr[gi];
  end

  assign pend_next = (pend_reg & ~clr) | d_in;
  assign drop_next = |hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      code_reg  <= '0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      code_reg  <= code_next;
      drop_reg  <= drop_next;
    end
  end

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic err_reg;
  logic multi_hot;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(d_in & (d_in - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else if (multi_hot) err_reg <= 1'b1;
  end

  assign err_out = err_reg;
`else
  assign err_out = 1'b0;
`endif

  assign code_out    = code_reg;
  assign valid_out   = (state_reg == HOLD);
  assign pending_out = pend_reg;
  assign drop_out    = drop_reg;

endmodule

// File: tb/tb_encoder_4_to_2_seq.sv
// Self-checking bench for encoder_4_to_2_seq: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_encoder_4_to_2_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] d_in = 4'b0;
  logic       ready_in = 1'b0;
  logic [1:0] code_out;
  logic       valid_out;
  logic [3:0] pending_out;
  logic       drop_out;
  logic       err_out;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  encoder_4_to_2_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_in        (d_in),
    .code_out    (code_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .pending_out (pending_out),
    .drop_out    (drop_out),
    .err_out     (err_out)
  );

  always #5 clk = ~clk;

  // Model: a set of outstanding request numbers plus the one currently offered.
  logic [3:0] m_pend;
  logic       m_valid;
  logic [1:0] m_code;
  logic       m_drop;
  logic       m_err;

  function automatic int highest(input logic [3:0] s);
    int h = -1;
    for (int i = 0; i < 4; i++) if (s[i]) h = i;
    return h;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 4'b0; m_valid = 1'b0; m_code = 2'd0; m_drop = 1'b0; m_err = 1'b0;
    end else begin
      logic [3:0] served;
      int         h;
      served = 4'b0;
      // The offer slot is free when nothing is offered or the offer is taken now.
      if (!m_valid || ready_in) begin
        h = highest(m_pend);
        if (h >= 0) begin
          m_code = 2'(h);
          m_valid = 1'b1;
          served[h] = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_drop = 1'b0;
      for (int i = 0; i < 4; i++)
        if (d_in[i] && m_pend[i] && !served[i]) m_drop = 1'b1;
      m_pend = (m_pend & ~served) | d_in;
`ifdef ENCODER_ONEHOT_CHECK_EN
      if ($countones(d_in) > 1) m_err = 1'b1;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    if (rst_n) begin
      chk("model_valid", 32'(valid_out), 32'(m_valid));
      if (m_valid) chk("model_code", 32'(code_out), 32'(m_code));
      chk("model_pend", 32'(pending_out), 32'(m_pend));
      chk("model_drop", 32'(drop_out), 32'(m_drop));
      chk("model_err", 32'(err_out), 32'(m_err));
    end
  end

  // Apply inputs for one edge; return just after that edge.
  task automatic cyc(input logic [3:0] d, input logic r);
    d_in = d;
    ready_in = r;
    @(posedge clk);
    #1;
    $display("[TB] t=%0t d_in=%b ready=%b -> valid=%b code=%0d pend=%b drop=%b err=%b",
             $time, d, r, valid_out, code_out, pending_out, drop_out, err_out);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_pend", 32'(pending_out), 0);
    chk("rst_code", 32'(code_out), 0);
    chk("rst_err", 32'(err_out), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(4'b0000, 1'b1);
    chk("idle_valid", 32'(valid_out), 0);

    // Single request
    cyc(4'b0100, 1'b1);
    chk("single_pend", 32'(pending_out), 4);
    chk("single_v0", 32'(valid_out), 0);
    cyc(4'b0000, 1'b1);
    chk("single_valid", 32'(valid_out), 1);
    chk("single_code", 32'(code_out), 2);
    chk("single_pend0", 32'(pending_out), 0);
    cyc(4'b0000, 1'b1);
    chk("single_done", 32'(valid_out), 0);

    // Multi-request priority
    cyc(4'b1011, 1'b1);
    chk("multi_pend", 32'(pending_out), 4'b1011);
    cyc(4'b0000, 1'b1);
    chk("multi_c3", 32'(code_out), 3);
    chk("multi_v3", 32'(valid_out), 1);
`ifdef ENCODER_ONEHOT_CHECK_EN
    chk("multi_err", 32'(err_out), 1);
`else
    chk("multi_err", 32'(err_out), 0);
`endif
    cyc(4'b0000, 1'b1);
    chk("multi_c1", 32'(code_out), 1);
    cyc(4'b0000, 1'b1);
    chk("multi_c0", 32'(code_out), 0);
    chk("multi_v0", 32'(valid_out), 1);
    cyc(4'b0000, 1'b1);
    chk("multi_done", 32'(valid_out), 0);

    // Backpressure
    cyc(4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0000, 1'b0);
      chk("bp_valid", 32'(valid_out), 1);
      chk("bp_code", 32'(code_out), 0);
    end
    cyc(4'b0000, 1'b1);
    chk("bp_accept", 32'(valid_out), 0);

    // Merge/drop: hold code 3 so that pend[2] stays pending
    cyc(4'b1000, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("merge_hold3", 32'(code_out), 3);
    cyc(4'b0100, 1'b0);
    chk("merge_nodrop", 32'(drop_out), 0);
    cyc(4'b0100, 1'b0);
    chk("merge_drop", 32'(drop_out), 1);
    chk("merge_pend", 32'(pending_out), 4);
    cyc(4'b0000, 1'b0);
    chk("merge_drop_pulse", 32'(drop_out), 0);
    cyc(4'b0000, 1'b1);
    chk("merge_c2", 32'(code_out), 2);
    chk("merge_v2", 32'(valid_out), 1);
    cyc(4'b0000, 1'b1);
    chk("merge_once", 32'(valid_out), 0);

    // Set wins over clear
    cyc(4'b1000, 1'b1);
    cyc(4'b1000, 1'b1);
    chk("swc_c3a", 32'(code_out), 3);
    chk("swc_pend", 32'(pending_out), 8);
    chk("swc_nodrop", 32'(drop_out), 0);
    cyc(4'b0000, 1'b1);
    chk("swc_c3b", 32'(code_out), 3);
    chk("swc_v3b", 32'(valid_out), 1);
    cyc(4'b0000, 1'b1);
    chk("swc_done", 32'(valid_out), 0);

    // Async reset in the middle of HOLD
    cyc(4'b1000, 1'b0);
    cyc(4'b0010, 1'b0);
    chk("rh_code", 32'(code_out), 3);
    chk("rh_valid", 32'(valid_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rh_rst_valid", 32'(valid_out), 0);
    chk("rh_rst_code", 32'(code_out), 0);
    chk("rh_rst_pend", 32'(pending_out), 0);
    chk("rh_rst_err", 32'(err_out), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(4'b0000, 1'b1);
    chk("rh_after_valid", 32'(valid_out), 0);
    cyc(4'b0000, 1'b1);
    chk("rh_after_pend", 32'(pending_out), 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
